// File: rtl/base_pkg.sv
// base_pkg: shared APB types, UART register map and the apb_reg_master state encoding.
package base_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef struct packed {
        addr_t      paddr;
        logic [2:0] pprot;
        logic       psel;
        logic       penable;
        logic       pwrite;
        data_t      pwdata;
        strb_t      pstrb;
    } apb_req_t;
    typedef struct packed {
        logic  pready;
        data_t prdata;
        logic  pslverr;
    } apb_resp_t;
    localparam addr_t REG_CTRL_ADDR         = 32'h00;
    localparam addr_t REG_CONFIG_ADDR       = 32'h04;
    localparam addr_t REG_CLK_DIV_ADDR      = 32'h08;
    localparam addr_t REG_TX_DATA_ADDR      = 32'h0C;
    localparam addr_t REG_RX_FIFO_STAT_ADDR = 32'h10;
    localparam addr_t REG_RX_DATA_ADDR      = 32'h14;
    localparam addr_t REG_STATUS_ADDR       = 32'h18;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_reg_master_state_e;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: clearable saturating cycle counter; expired_o flags the LIMIT-th counted cycle.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
    assign expired_o = cnt_q == LAST;
endmodule

// File: rtl/apb_reg_master.sv
// apb_reg_master: single-beat command to APB4 initiator (IDLE/SETUP/ACCESS/RESP).
// APB_REG_MASTER_TIMEOUT_EN adds an ACCESS-phase timeout of TIMEOUT_CYCLES cycles.
module apb_reg_master
    import base_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      cmd_valid_i,
    output logic      cmd_ready_o,
    input  logic      cmd_write_i,
    input  addr_t     cmd_addr_i,
    input  data_t     cmd_wdata_i,
    input  strb_t     cmd_strb_i,
    output apb_req_t  apb_req_o,
    input  apb_resp_t apb_resp_i,
    output logic      rsp_valid_o,
    input  logic      rsp_ready_i,
    output data_t     rsp_rdata_o,
    output logic      rsp_err_o,
    output logic      rsp_timeout_o
);
    apb_reg_master_state_e state_q, state_d;
    addr_t addr_q, addr_d;
    data_t wdata_q, wdata_d, rdata_q, rdata_d;
    strb_t strb_q, strb_d;
    logic  write_q, write_d, err_q, err_d, tmo_q, tmo_d;
    logic  timeout;
`ifdef APB_REG_MASTER_TIMEOUT_EN
    logic expired;
    apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == SETUP),
        .inc_i     (state_q == ACCESS && !apb_resp_i.pready),
        .expired_o (expired)
    );
    assign timeout = state_q == ACCESS && expired;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                rdata_d = '0;
                tmo_d   = 1'b0;
                err_d   = cmd_addr_i[1:0] != 2'b00;
                state_d = err_d ? RESP : SETUP;
                addr_d  = cmd_addr_i;
                write_d = cmd_write_i;
                // Write-only fields are zeroed here so reads drive 0 on the bus.
                wdata_d = cmd_write_i ? cmd_wdata_i : '0;
                strb_d  = cmd_write_i ? cmd_strb_i : '0;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (apb_resp_i.pready || timeout) begin
                state_d = RESP;
                err_d   = !apb_resp_i.pready || apb_resp_i.pslverr;
                tmo_d   = !apb_resp_i.pready;
                rdata_d = (write_q || err_d) ? '0 : apb_resp_i.prdata;
            end
            RESP: state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end
    always_comb begin
        apb_req_o = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            apb_req_o.paddr   = addr_q;
            apb_req_o.psel    = 1'b1;
            apb_req_o.penable = state_q == ACCESS;
            apb_req_o.pwrite  = write_q;
            apb_req_o.pwdata  = wdata_q;
            apb_req_o.pstrb   = strb_q;
        end
    end
    assign cmd_ready_o   = state_q == IDLE;
    assign rsp_valid_o   = state_q == RESP;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;
endmodule

// File: tb/tb_apb_reg_master.sv
// tb_apb_reg_master: directed scoreboard bench for apb_reg_master (timeout case follows APB_REG_MASTER_TIMEOUT_EN).
module tb_apb_reg_master;
    import base_pkg::*;
    logic      clk_i = 1'b0;
    logic      rst_i = 1'b1;
    logic      cmd_valid_i = 1'b0;
    logic      cmd_ready_o;
    logic      cmd_write_i = 1'b0;
    addr_t     cmd_addr_i = '0;
    data_t     cmd_wdata_i = '0;
    strb_t     cmd_strb_i = '0;
    apb_req_t  apb_req_o;
    apb_resp_t apb_resp_i = '0;
    logic      rsp_valid_o;
    logic      rsp_ready_i = 1'b0;
    data_t     rsp_rdata_o;
    logic      rsp_err_o;
    logic      rsp_timeout_o;
    int checks = 0;
    int errors = 0;
    typedef struct {
        data_t rdata;
        logic  err;
        logic  tmo;
    } exp_t;
    exp_t sb_q[$];

    apb_reg_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_strb_i    (cmd_strb_i),
        .apb_req_o     (apb_req_o),
        .apb_resp_i    (apb_resp_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input addr_t a, input data_t wd, input strb_t st);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = wd;
        cmd_strb_i  = st;
        tick();
        cmd_valid_i = 1'b0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
    endtask

    task automatic check_setup(input logic w, input addr_t a, input data_t wd, input strb_t st);
        chk("setup_psel", apb_req_o.psel, 1);
        chk("setup_penable", apb_req_o.penable, 0);
        chk("setup_paddr", apb_req_o.paddr, a);
        chk("setup_pwrite", apb_req_o.pwrite, w);
        chk("setup_pwdata", apb_req_o.pwdata, w ? wd : 32'h0);
        chk("setup_pstrb", apb_req_o.pstrb, w ? st : 4'h0);
        chk("setup_pprot", apb_req_o.pprot, 0);
        chk("setup_cmd_ready", cmd_ready_o, 0);
        chk("setup_rsp_valid", rsp_valid_o, 0);
    endtask

    task automatic check_rsp(input int hold);
        exp_t e;
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_psel", apb_req_o.psel, 0);
        chk("rsp_paddr_zero", apb_req_o.paddr, 0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed response with no expected entry");
        end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_err", rsp_err_o, e.err);
            chk("rsp_timeout", rsp_timeout_o, e.tmo);
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", rsp_valid_o, 1);
                chk("hold_rdata", rsp_rdata_o, e.rdata);
                chk("hold_err", rsp_err_o, e.err);
                chk("hold_timeout", rsp_timeout_o, e.tmo);
                chk("hold_cmd_ready", cmd_ready_o, 0);
            end
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("post_rsp_valid", rsp_valid_o, 0);
        chk("post_cmd_ready", cmd_ready_o, 1);
    endtask

    task automatic xfer(input logic w, input addr_t a, input data_t wd, input strb_t st,
                        input int waits, input data_t rd, input logic se, input int hold);
        exp_t e;
        logic mis;
        mis = a[1:0] != 2'b00;
        e.rdata = (mis || w || se) ? 32'h0 : rd;
        e.err = mis || se;
        e.tmo = 1'b0;
        sb_q.push_back(e);
        apb_resp_i = '{pready: 1'b0, prdata: rd, pslverr: se};
        drive_cmd(w, a, wd, st);
        if (mis) begin
            chk("mis_psel", apb_req_o.psel, 0);
        end else begin
            check_setup(w, a, wd, st);
            for (int i = 0; i <= waits; i++) begin
                tick();
                chk("access_psel", apb_req_o.psel, 1);
                chk("access_penable", apb_req_o.penable, 1);
                chk("access_paddr", apb_req_o.paddr, a);
                chk("access_pwdata", apb_req_o.pwdata, w ? wd : 32'h0);
                chk("access_rsp_valid", rsp_valid_o, 0);
                apb_resp_i.pready = i == waits;
            end
            tick();
            apb_resp_i = '0;
        end
        check_rsp(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_timeout", rsp_timeout_o, 0);
        chk("rst_req_psel", apb_req_o.psel, 0);
        chk("rst_req_paddr", apb_req_o.paddr, 0);
        chk("rst_req_zero", {31'h0, apb_req_o == '0}, 1);
        rst_i = 1'b0;
        tick();
        xfer(1'b1, REG_CTRL_ADDR, 32'h0000_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(1'b0, REG_RX_FIFO_STAT_ADDR, 32'h1234_5678, 4'hF, 2, 32'h0000_0005, 1'b0, 0);
        xfer(1'b0, 32'h06, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0, 0);
        xfer(1'b1, REG_STATUS_ADDR, 32'hA5A5_0F0F, 4'h3, 1, 32'h0, 1'b1, 4);
        xfer(1'b1, REG_CLK_DIV_ADDR, 32'h0000_0364, 4'h5, 3, 32'h0, 1'b0, 2);
        xfer(1'b0, REG_CONFIG_ADDR, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 1);
        xfer(1'b1, 32'h0D, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0, 1);
        // Stalled slave: pready never rises on its own.
        apb_resp_i = '{pready: 1'b0, prdata: 32'h0000_ABCD, pslverr: 1'b0};
        drive_cmd(1'b0, REG_CLK_DIV_ADDR, 32'h0, 4'h0);
        check_setup(1'b0, REG_CLK_DIV_ADDR, 32'h0, 4'h0);
`ifdef APB_REG_MASTER_TIMEOUT_EN
        e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
        sb_q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_access", {30'h0, apb_req_o.psel, apb_req_o.penable}, 3);
            chk("tmo_rsp_valid", rsp_valid_o, 0);
        end
        tick();
        check_rsp(0);
`else
        e = '{rdata: 32'h0000_ABCD, err: 1'b0, tmo: 1'b0};
        sb_q.push_back(e);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("stuck_access", {29'h0, apb_req_o.psel, apb_req_o.penable, rsp_valid_o}, 6);
        end
        apb_resp_i.pready = 1'b1;
        tick();
        apb_resp_i = '0;
        check_rsp(0);
`endif
        // Reset during the second ACCESS cycle discards the transfer.
        apb_resp_i = '{pready: 1'b0, prdata: 32'h7777_7777, pslverr: 1'b0};
        drive_cmd(1'b1, REG_CONFIG_ADDR, 32'h0000_00FF, 4'hF);
        tick();
        tick();
        chk("pre_rst_access", {30'h0, apb_req_o.psel, apb_req_o.penable}, 3);
        rst_i = 1'b1;
        tick();
        chk("rst_mid_psel", apb_req_o.psel, 0);
        chk("rst_mid_penable", apb_req_o.penable, 0);
        chk("rst_mid_rsp_valid", rsp_valid_o, 0);
        rst_i = 1'b0;
        apb_resp_i = '0;
        tick();
        chk("rst_rel_cmd_ready", cmd_ready_o, 1);
        chk("rst_rel_rsp_valid", rsp_valid_o, 0);
        xfer(1'b0, REG_RX_DATA_ADDR, 32'h0, 4'h0, 0, 32'h0000_0042, 1'b0, 0);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_reg_master.md
# apb_reg_master

APB initiator that turns single-beat register commands into APB4 transfers on the UART peripheral's register port. It is the requesting end of the `base_pkg` APB interface, used by the bench-side and SoC-side control logic to program CTRL/CONFIG/CLK_DIV and to drain the RX FIFO. It runs one transfer at a time through an IDLE/SETUP/ACCESS/RESP state machine, with valid/ready handshakes on both the command and response sides.

## Interface
- `TIMEOUT_CYCLES`, default 256: the maximum number of ACCESS cycles without `pready` before the transfer is aborted. Only used with the timeout feature compiled in; must be ≥ 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset: synchronous, active-high.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted on `cmd_valid_i && cmd_ready_o`.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  `base_pkg::addr_t` (32)  byte address.
- `cmd_wdata_i`  in  `base_pkg::data_t` (32)  write data.
- `cmd_strb_i`  in  `base_pkg::strb_t` (4)  write byte strobes.
- `apb_req_o`  out  `base_pkg::apb_req_t`  the APB request: paddr, pprot, psel, penable, pwrite, pwdata, pstrb.
- `apb_resp_i`  in  `base_pkg::apb_resp_t`  the APB response: pready, prdata, pslverr.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed on `rsp_valid_o && rsp_ready_i`.
- `rsp_rdata_o`  out  32  read data; 0 for writes and for errors.
- `rsp_err_o`  out  1  slave error, misaligned address, or timeout.
- `rsp_timeout_o`  out  1  the transfer was aborted by timeout.

## Operation
**IDLE**
- `cmd_ready_o` = 1 in IDLE only.
- On accept with `cmd_addr_i[1:0] == 0`: register the command and go to SETUP.
- On accept with `cmd_addr_i[1:0] != 0`: no bus activity; go to RESP with `rsp_err_o` = 1 and `rsp_rdata_o` = 0.

**SETUP**
- `psel` = 1, `penable` = 0. Always lasts exactly one cycle, then go to ACCESS.

**ACCESS**
- `psel` = 1, `penable` = 1. Hold until `pready` = 1.
- On `pready`, capture into the response registers and go to RESP:
  - `prdata` for reads; 0 for writes.
  - `rsp_err_o` = `pslverr`.

**RESP**
- `rsp_valid_o` = 1, `psel` = `penable` = 0.
- Return to IDLE on `rsp_ready_i`.
- Response fields stay stable while `rsp_ready_i` = 0.

**Request field rules**
- paddr, pwrite, pwdata and pstrb come from registers. They are stable from SETUP through the last ACCESS cycle.
- pprot = 3'b000.
- pstrb = 0 and pwdata = 0 on reads.
- Outside SETUP/ACCESS all request fields are driven to 0.

**Reset**
- A synchronous reset in any state returns to IDLE at the next edge. Any in-flight transfer or pending response is discarded.
- Reset values: `cmd_ready_o` = 1 once out of reset; `rsp_valid_o` = 0; `rsp_rdata_o` = 0; `rsp_err_o` = 0; `rsp_timeout_o` = 0; every `apb_req_o` field = 0.

## Timing
- Accept at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With zero wait states, `rsp_valid_o` is high in cycle 3. Each wait state adds one cycle.
- Misaligned command: `rsp_valid_o` in cycle 1.
- Peak throughput is one transfer per 4 cycles; commands are never pipelined.
- `cmd_ready_o` falls the cycle after an accept and rises the cycle after the response handshake.

## Configuration
- Macro: `APB_REG_MASTER_TIMEOUT_EN`.
- **Defined:**
  - An ACCESS-cycle counter clears on entering SETUP and increments each ACCESS cycle with `pready` = 0.
  - If `pready` is still 0 in the `TIMEOUT_CYCLES`-th ACCESS cycle, go to RESP next cycle with `rsp_err_o` = 1, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0.
  - `pready` seen in that same cycle wins: it is a normal completion, not a timeout.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Undefined:** ACCESS waits indefinitely, `rsp_timeout_o` is tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Already in `base_pkg`: `apb_req_t`, `apb_resp_t`, `addr_t`, `data_t`, `strb_t` and the `REG_*_ADDR` constants.
- Add the state enum `apb_reg_master_state_e` (IDLE, SETUP, ACCESS, RESP) to `base_pkg`.
- One sub-module, `apb_timeout_cnt`: a clearable saturating counter with an `expired` flag. It is instantiated only under the macro.

## Test plan
- Write 0x0000_0001 to 0x00 (CTRL), slave with 0 wait states → psel in cycle 1, penable in cycle 2, `rsp_valid_o` in cycle 3 with err = 0 and rdata = 0.
- Read 0x10 (RX_FIFO_STAT), slave with 2 wait states returning 0x5 → pstrb = 0, `rsp_valid_o` in cycle 5, `rsp_rdata_o` = 0x5.
- Read 0x06 → psel never asserted, `rsp_valid_o` in cycle 1 with `rsp_err_o` = 1.
- Write to 0x18, slave returns `pslverr` = 1 → `rsp_err_o` = 1, `rsp_timeout_o` = 0. Hold `rsp_ready_i` low for 4 cycles: response stable and `cmd_ready_o` = 0 throughout.
- With the macro defined and `TIMEOUT_CYCLES` = 16, `pready` stuck at 0 → exactly 16 ACCESS cycles, then response with err = 1 and timeout = 1. With the macro undefined, ACCESS persists for 1000 cycles.
- Assert `rst_i` during the second ACCESS cycle → next cycle psel = penable = 0, `rsp_valid_o` = 0, `cmd_ready_o` = 1 once reset is released.
